// File: rtl/rx_round_sat_pipe_if.sv
// rtl/rx_round_sat_pipe_if.sv - stream and control bundle for the RX rounder/saturator
interface rx_round_sat_pipe_if #(
    parameter int IN_WIDTH  = 16,
    parameter int OUT_WIDTH = 8,
    parameter int NUM_CH    = 2,
    parameter int SHIFT_W   = 4,
    parameter int CNT_WIDTH = 16
);
    logic                          in_valid;
    logic                          in_ready;
    logic [NUM_CH*IN_WIDTH-1:0]    in_data;
    logic [SHIFT_W-1:0]            shift;
    logic [1:0]                    rnd_mode;
    logic                          out_valid;
    logic                          out_ready;
    logic [NUM_CH*OUT_WIDTH-1:0]   out_data;
    logic [NUM_CH-1:0]             out_sat;
    logic [CNT_WIDTH-1:0]          sat_cnt;
    logic                          sat_clr;

    modport master (
        output in_valid, in_data, shift, rnd_mode, out_ready, sat_clr,
        input  in_ready, out_valid, out_data, out_sat, sat_cnt
    );

    modport slave (
        input  in_valid, in_data, shift, rnd_mode, out_ready, sat_clr,
        output in_ready, out_valid, out_data, out_sat, sat_cnt
    );
endinterface

// File: rtl/rx_round_sat_pipe.sv
// rtl/rx_round_sat_pipe.sv - 2-stage multi-channel shift/round/saturate pipe; RX_ROUND_SAT_CNT_EN enables sat_cnt
module rx_round_sat_pipe #(
    parameter int IN_WIDTH  = 16,
    parameter int OUT_WIDTH = 8,
    parameter int NUM_CH    = 2,
    parameter int SHIFT_W   = 4,
    parameter int CNT_WIDTH = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    rx_round_sat_pipe_if.slave bus
);
    localparam int RW   = IN_WIDTH + 1;
    localparam int SA_W = $clog2(IN_WIDTH);
    localparam logic [OUT_WIDTH-1:0] OUT_MAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    localparam logic [OUT_WIDTH-1:0] OUT_MIN = {1'b1, {(OUT_WIDTH-1){1'b0}}};

    logic                        s1_valid;
    logic                        s2_valid;
    logic                        s2_adv;
    logic                        in_ready;
    logic [SA_W-1:0]             sh_eff;
    logic [NUM_CH*RW-1:0]        rnd_next;
    logic [NUM_CH*RW-1:0]        s1_data;
    logic [NUM_CH*OUT_WIDTH-1:0] sat_data_next;
    logic [NUM_CH-1:0]           sat_next;
    logic [NUM_CH*OUT_WIDTH-1:0] out_data_q;
    logic [NUM_CH-1:0]           out_sat_q;

    // Rounded quotient keeps one extra bit so a carry out of the top is never wrapped.
    function automatic logic [RW-1:0] round_one(
        input logic [IN_WIDTH-1:0] x,
        input logic [SA_W-1:0]     s,
        input logic [1:0]          mode
    );
        logic signed [RW-1:0] ext;
        logic signed [RW-1:0] fl;
        logic [RW-1:0]        rem;
        logic [RW-1:0]        half;
        logic                 up;
        ext  = {x[IN_WIDTH-1], x};
        fl   = ext >>> s;
        rem  = ext & ~({RW{1'b1}} << s);
        half = (RW'(1) << s) >> 1;
        up   = 1'b0;
        if (s != '0) begin
            case (mode)
                2'b01:   up = (rem >= half);
                2'b10:   up = (rem > half) || ((rem == half) && fl[0]);
                2'b11:   up = (rem > half) || ((rem == half) && !ext[RW-1]);
                default: up = 1'b0;
            endcase
        end
        return fl + RW'(up);
    endfunction

    always_comb begin
        sh_eff = SA_W'(bus.shift);
        if (int'(bus.shift) > IN_WIDTH - 1)
            sh_eff = SA_W'(IN_WIDTH - 1);
    end

    always_comb begin
        rnd_next = '0;
        for (int ch = 0; ch < NUM_CH; ch++)
            rnd_next[ch*RW +: RW] = round_one(bus.in_data[ch*IN_WIDTH +: IN_WIDTH], sh_eff, bus.rnd_mode);
    end

    // A value fits when every bit from the output sign bit upward agrees.
    always_comb begin
        logic [RW-1:0]           r;
        logic [RW-OUT_WIDTH:0]   hi;
        sat_data_next = '0;
        sat_next      = '0;
        r             = '0;
        hi            = '0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            r  = s1_data[ch*RW +: RW];
            hi = r[RW-1:OUT_WIDTH-1];
            if ((&hi) || !(|hi)) begin
                sat_data_next[ch*OUT_WIDTH +: OUT_WIDTH] = r[OUT_WIDTH-1:0];
            end else begin
                sat_next[ch] = 1'b1;
                sat_data_next[ch*OUT_WIDTH +: OUT_WIDTH] = r[RW-1] ? OUT_MIN : OUT_MAX;
            end
        end
    end

    assign s2_adv   = !s2_valid || bus.out_ready;
    assign in_ready = !s1_valid || s2_adv;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid   <= 1'b0;
            s1_data    <= '0;
            s2_valid   <= 1'b0;
            out_data_q <= '0;
            out_sat_q  <= '0;
        end else begin
            if (in_ready) begin
                s1_valid <= bus.in_valid;
                if (bus.in_valid)
                    s1_data <= rnd_next;
            end
            if (s2_adv) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    out_data_q <= sat_data_next;
                    out_sat_q  <= sat_next;
                end
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = s2_valid;
    assign bus.out_data  = out_data_q;
    assign bus.out_sat   = out_sat_q;

`ifdef RX_ROUND_SAT_CNT_EN
    logic [CNT_WIDTH-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_q <= '0;
        else if (bus.sat_clr)
            cnt_q <= '0;
        else if (s2_valid && bus.out_ready && (|out_sat_q) && !(&cnt_q))
            cnt_q <= cnt_q + CNT_WIDTH'(1);
    end

    assign bus.sat_cnt = cnt_q;
`else
    logic unused_sat_clr;
    assign unused_sat_clr = bus.sat_clr;
    assign bus.sat_cnt    = '0;
`endif
endmodule
